a2d_spi_resp: RTL and testbench
===============================

Name: a2d_spi_resp

Overview:
- SPI responder (slave) for the 16-bit A2D channel-read protocol.
- Emulates a pipelined 8-channel 12-bit ADC. Each transaction receives a command word on MOSI and returns, on MISO, the conversion of the channel selected by the previous transaction.
- Sits opposite the A2D SPI master: in the bench as the ADC model, and in-chip wherever a block must answer A2D-style reads.
- All SPI inputs are oversampled in the clk domain.

Parameters:
- NUM_CH, 8, number of channels; channel index width is 3 bits.
- DATA_W, 12, conversion width; response word is {(16-DATA_W) zeros, data}.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset (decided, see Behaviour).
- SS_n  in  1  SPI select, active low, asynchronous to clk.
- SCLK  in  1  SPI clock, idles high, asynchronous to clk.
- MOSI  in  1  command bit from master.
- MISO  out  1  response bit to master.
- ch_data  in  NUM_CH*DATA_W  channel values; channel k occupies bits [k*DATA_W +: DATA_W].
- cmd_rcvd  out  16  last complete command word.
- cmd_vld  out  1  one-clk pulse when cmd_rcvd updates.
- frm_err  out  1  one-clk pulse when a frame ends with a rise count other than 16.
- ch_ptr  out  3  channel to be returned in the next transaction.

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk.
- Reset values:
  - MISO=0, cmd_rcvd=16'h0000, cmd_vld=0, frm_err=0, ch_ptr=0.
  - Shift register 0, bit counter 0, state IDLE.
  - Synchronizer flops preset to 1 for SS_n and SCLK, 0 for MOSI.
- Synchronization: SS_n, SCLK and MOSI each pass through 2 flops, plus a third flop on SS_n/SCLK for edge detection.
  - Edge detectors: sclk_rise, sclk_fall, ss_fall, ss_rise.
  - Minimum supported ratio is clk >= 8x SCLK.
- State machine, IDLE / SHIFT:
  - IDLE: on ss_fall:
    - Load tx shift register with {zeros, ch_data[ch_ptr]}, snapshotted that cycle.
    - Clear bit counter; go to SHIFT.
  - SHIFT, on sclk_rise: sample synced MOSI into the rx sample flop; bit counter +1, saturating at 31.
  - SHIFT, on sclk_fall with bit counter != 0: shift the shift register left, bringing in the sample flop at bit 0. A fall before the first rise is ignored.
  - SHIFT, on ss_rise: go to IDLE.
    - If bit counter == 16: cmd_rcvd = {shreg[14:0], sample}; cmd_vld pulses the next cycle; ch_ptr = that word's bits [13:11].
    - Otherwise: frm_err pulses; cmd_rcvd and ch_ptr are unchanged.
- The same shift register serves tx and rx: the MSB is transmitted, MOSI bits enter at the LSB.
- MISO output:
  - In SHIFT, MISO = shreg[15]. The MSB is valid before the first SCLK rise and changes only on counted falls.
  - In IDLE, MISO = 0.
- Latency:
  - Response data is one transaction behind the command.
  - The first transaction after reset returns channel 0.
  - cmd_vld asserts 1 clk after the synchronized SS_n rise.
- Command bits other than [13:11] are ignored, but are preserved in cmd_rcvd.
- ch_ptr >= NUM_CH (when NUM_CH < 8) returns all zeros.
- Boundary cases:
  - ss_rise coincident with sclk_rise: the sample is taken first, then the frame is evaluated on the updated count.
  - ss_fall while in SHIFT (glitch, no rise seen): restart the load as if from IDLE.
  - ch_data changes mid-frame: no effect on the current response.
  - rst_n asserted mid-frame: immediate return to reset values; the partial frame is discarded with no frm_err.
  - SCLK edges while SS_n is high: ignored.

Test Plan:
- Reset, then a 16-bit frame with cmd 16'h0000 (ch_data ch0=12'hABC): MISO returns 16'h0ABC; cmd_vld pulses once; cmd_rcvd=16'h0000; ch_ptr=0.
- Frame cmd 16'h2800 (ch5) with ch5=12'h123, then frame cmd 16'h0000: first response is ch0 data, second is 16'h0123; ch_ptr goes 5, then 0.
- Three-frame round robin matching the master sequence 16'h0000, 16'h2000, 16'h2800 with ch0=12'h111, ch4=12'h444, ch5=12'h555: responses are stale-by-one, ending with 16'h0444, then 16'h0555 on a fourth frame.
- Aborted frame: SS_n rises after 9 SCLK rises: frm_err pulses once; cmd_rcvd and ch_ptr are unchanged; the next full frame behaves normally.
- ch_data[ch0] changed from 12'hFFF to 12'h000 at bit 4 of a frame: MISO still delivers 16'h0FFF.
- rst_n pulsed low at bit 8: MISO=0 and ch_ptr=0 immediately; no cmd_vld or frm_err; the next frame returns ch0.

Source files
------------

// File: rtl/a2d_spi_resp.sv
// SPI responder emulating a pipelined 8-channel 12-bit ADC for the 16-bit A2D read protocol.
// All SPI pins are oversampled in the clk domain; the response is the channel chosen by the previous frame.
module a2d_spi_resp #(
    parameter int NUM_CH = 8,
    parameter int DATA_W = 12
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       SS_n,
    input  logic                       SCLK,
    input  logic                       MOSI,
    output logic                       MISO,
    input  logic [NUM_CH*DATA_W-1:0]   ch_data,
    output logic [15:0]                cmd_rcvd,
    output logic                       cmd_vld,
    output logic                       frm_err,
    output logic [2:0]                 ch_ptr
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t      state;
    logic [2:0]  ss_sync;
    logic [2:0]  sclk_sync;
    logic [1:0]  mosi_sync;
    logic [15:0] shreg;
    logic [4:0]  bit_cnt;
    logic        sample;

    logic        ss_fall, ss_rise, sclk_rise, sclk_fall, mosi_s;
    logic [4:0]  cnt_nxt;
    logic        samp_nxt;
    logic [15:0] rx_word;

    // Zero-extended conversion word for a channel; out-of-range channels read as zero.
    function automatic logic [15:0] ch_word(input logic [2:0] p,
                                            input logic [NUM_CH*DATA_W-1:0] d);
        logic [15:0] w;
        w = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (p == 3'(k)) w[DATA_W-1:0] = d[k*DATA_W +: DATA_W];
        end
        return w;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_sync   <= 3'b111;
            sclk_sync <= 3'b111;
            mosi_sync <= 2'b00;
        end else begin
            ss_sync   <= {ss_sync[1:0], SS_n};
            sclk_sync <= {sclk_sync[1:0], SCLK};
            mosi_sync <= {mosi_sync[0], MOSI};
        end
    end

    assign ss_fall   =  ss_sync[2]   & ~ss_sync[1];
    assign ss_rise   = ~ss_sync[2]   &  ss_sync[1];
    assign sclk_fall =  sclk_sync[2] & ~sclk_sync[1];
    assign sclk_rise = ~sclk_sync[2] &  sclk_sync[1];
    assign mosi_s    =  mosi_sync[1];

    // A rise coincident with the SS_n rise must be folded in before the frame is judged.
    always_comb begin
        cnt_nxt  = bit_cnt;
        samp_nxt = sample;
        if (sclk_rise) begin
            samp_nxt = mosi_s;
            if (bit_cnt != 5'd31) cnt_nxt = bit_cnt + 5'd1;
        end
    end

    assign rx_word = {shreg[14:0], samp_nxt};
    assign MISO    = (state == SHIFT) & shreg[15];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            sample   <= 1'b0;
            cmd_rcvd <= '0;
            cmd_vld  <= 1'b0;
            frm_err  <= 1'b0;
            ch_ptr   <= '0;
        end else begin
            cmd_vld <= 1'b0;
            frm_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (ss_fall) begin
                        shreg   <= ch_word(ch_ptr, ch_data);
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (ss_fall) begin
                        shreg   <= ch_word(ch_ptr, ch_data);
                        bit_cnt <= '0;
                    end else begin
                        bit_cnt <= cnt_nxt;
                        sample  <= samp_nxt;
                        if (sclk_fall && bit_cnt != 5'd0)
                            shreg <= {shreg[14:0], sample};
                        if (ss_rise) begin
                            state <= IDLE;
                            if (cnt_nxt == 5'd16) begin
                                cmd_rcvd <= rx_word;
                                cmd_vld  <= 1'b1;
                                ch_ptr   <= rx_word[13:11];
                            end else begin
                                frm_err  <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_a2d_spi_resp.sv
// Scoreboard bench for a2d_spi_resp: directed frames push expected responses, monitors compare.
`timescale 1ns/1ps
module tb_a2d_spi_resp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        SS_n = 1'b1;
    logic        SCLK = 1'b1;
    logic        MOSI = 1'b0;
    logic        MISO;
    logic [95:0] ch_data = '0;
    logic [15:0] cmd_rcvd;
    logic        cmd_vld;
    logic        frm_err;
    logic [2:0]  ch_ptr;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_miso_q[$];
    logic [18:0] exp_cmd_q[$];   // {ch_ptr, cmd_rcvd}
    int          exp_err = 0;

    a2d_spi_resp dut (
        .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
        .ch_data(ch_data), .cmd_rcvd(cmd_rcvd), .cmd_vld(cmd_vld), .frm_err(frm_err),
        .ch_ptr(ch_ptr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [15:0] miso, input logic [15:0] cmd, input logic [2:0] ptr);
        exp_miso_q.push_back(miso);
        exp_cmd_q.push_back({ptr, cmd});
    endtask

    // One master frame: MOSI changes on falls, SCLK idles high; optional ch0 change mid-frame.
    task automatic frame(input logic [15:0] cmd, input int nbits, input int chg_bit,
                         input logic [11:0] chg_val, input bit coinc, input bit end_ss);
        SS_n = 1'b0;
        wait_clk(10);
        for (int i = 0; i < nbits; i++) begin
            if (i == chg_bit) ch_data[11:0] = chg_val;
            SCLK = 1'b0;
            MOSI = cmd[15-i];
            wait_clk(8);
            SCLK = 1'b1;
            if (coinc && i == nbits - 1) begin
                #1 SS_n = 1'b1;
            end
            if (i != nbits - 1 || !coinc) wait_clk(8);
        end
        if (end_ss) begin
            if (!coinc) begin
                wait_clk(4);
                SS_n = 1'b1;
            end
            wait_clk(20);
        end
    endtask

    // MISO monitor: assemble bits at SCLK rises; full 16-bit frames are scored.
    initial begin
        logic [15:0] word;
        int          mcnt;
        forever begin
            @(negedge SS_n);
            mcnt = 0;
            word = '0;
            while (SS_n === 1'b0) begin
                @(posedge SCLK or posedge SS_n);
                if (SS_n === 1'b0) begin
                    word = {word[14:0], MISO};
                    mcnt++;
                end
            end
            if (mcnt == 16) begin
                if (exp_miso_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL miso_unexpected: got %h expected none", word);
                end else begin
                    check("miso_word", {3'b0, word}, {3'b0, exp_miso_q.pop_front()});
                end
            end
        end
    end

    // Command/error monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (cmd_vld === 1'b1) begin
            if (exp_cmd_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL cmd_vld_unexpected: got cmd %h expected no pulse", cmd_rcvd);
            end else begin
                check("cmd_rcvd_ptr", {ch_ptr, cmd_rcvd}, exp_cmd_q.pop_front());
            end
        end
        if (frm_err === 1'b1) begin
            checks++;
            if (exp_err == 0) begin
                errors++;
                $display("FAIL frm_err_unexpected: got 1 expected 0");
            end else begin
                exp_err--;
            end
        end
    end

    initial begin
        ch_data[0*12 +: 12] = 12'hABC;
        ch_data[5*12 +: 12] = 12'h123;
        wait_clk(3);
        check("rst_miso",    {18'b0, MISO},    19'h0);
        check("rst_cmd",     {3'b0, cmd_rcvd}, 19'h0);
        check("rst_vld",     {18'b0, cmd_vld}, 19'h0);
        check("rst_err",     {18'b0, frm_err}, 19'h0);
        check("rst_ptr",     {16'b0, ch_ptr},  19'h0);
        rst_n = 1'b1;
        wait_clk(5);

        // SCLK activity with SS_n high must not start anything
        repeat (4) begin
            SCLK = 1'b0; wait_clk(8); SCLK = 1'b1; wait_clk(8);
        end

        push(16'h0ABC, 16'h0000, 3'd0); frame(16'h0000, 16, -1, 12'h0, 0, 1);
        check("t1_ptr", {16'b0, ch_ptr}, 19'd0);

        push(16'h0ABC, 16'h2800, 3'd5); frame(16'h2800, 16, -1, 12'h0, 0, 1);
        check("t2_ptr5", {16'b0, ch_ptr}, 19'd5);
        push(16'h0123, 16'h0000, 3'd0); frame(16'h0000, 16, -1, 12'h0, 0, 1);

        ch_data[0*12 +: 12] = 12'h111;
        ch_data[4*12 +: 12] = 12'h444;
        ch_data[5*12 +: 12] = 12'h555;
        push(16'h0111, 16'h0000, 3'd0); frame(16'h0000, 16, -1, 12'h0, 0, 1);
        push(16'h0111, 16'h2000, 3'd4); frame(16'h2000, 16, -1, 12'h0, 0, 1);
        push(16'h0444, 16'h2800, 3'd5); frame(16'h2800, 16, -1, 12'h0, 0, 1);
        // SS_n rises together with the last SCLK rise
        push(16'h0555, 16'h0000, 3'd0); frame(16'h0000, 16, -1, 12'h0, 1, 1);

        push(16'h0111, 16'h2800, 3'd5); frame(16'h2800, 16, -1, 12'h0, 0, 1);
        exp_err++;
        frame(16'h1800, 9, -1, 12'h0, 0, 1);
        check("abort_cmd", {3'b0, cmd_rcvd}, {3'b0, 16'h2800});
        check("abort_ptr", {16'b0, ch_ptr}, 19'd5);
        check("abort_err_seen", 19'(exp_err), 19'd0);
        push(16'h0555, 16'h0000, 3'd0); frame(16'h0000, 16, -1, 12'h0, 0, 1);

        ch_data[0*12 +: 12] = 12'hFFF;
        push(16'h0FFF, 16'h0000, 3'd0); frame(16'h0000, 16, 4, 12'h000, 0, 1);

        push(16'h0000, 16'h2800, 3'd5); frame(16'h2800, 16, -1, 12'h0, 0, 1);
        frame(16'h0000, 8, -1, 12'h0, 0, 0);
        rst_n = 1'b0;
        #1;
        check("midrst_miso", {18'b0, MISO},    19'h0);
        check("midrst_ptr",  {16'b0, ch_ptr},  19'h0);
        check("midrst_cmd",  {3'b0, cmd_rcvd}, 19'h0);
        wait_clk(3);
        SS_n = 1'b1;
        SCLK = 1'b1;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(10);
        ch_data[0*12 +: 12] = 12'h5A5;
        push(16'h05A5, 16'h0000, 3'd0); frame(16'h0000, 16, -1, 12'h0, 0, 1);

        wait_clk(20);
        check("miso_q_empty", 19'(exp_miso_q.size()), 19'd0);
        check("cmd_q_empty",  19'(exp_cmd_q.size()),  19'd0);
        check("err_pending",  19'(exp_err),           19'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
